// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode hex display driver with frame-synchronous
// value capture, optional leading-zero suppression and a global blank.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load_en,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          wrap;
    logic [3:0]    nib;
    logic          lead_zero;
    logic          digit_off;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        wrap   = (cnt_q == CNT_MAX);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        idx_d  = wrap ? idx_q + 2'd1 : idx_q;
        // Capture only on the last cycle of digit 3 so a frame never tears.
        disp_d = (wrap && idx_q == 2'd3 && load_en) ? value : disp_q;

        nib       = 4'h0;
        lead_zero = 1'b0;
        case (idx_q)
            2'd0: nib = disp_q[3:0];
            2'd1: begin nib = disp_q[7:4];   lead_zero = (disp_q[15:4] == '0);  end
            2'd2: begin nib = disp_q[11:8];  lead_zero = (disp_q[15:8] == '0);  end
            default: begin nib = disp_q[15:12]; lead_zero = (disp_q[15:12] == '0); end
        endcase

        digit_off = blank || (LZ_BLANK && lead_zero);
        an_d      = digit_off ? 4'b1111   : ~(4'b0001 << idx_q);
        seg_d     = digit_off ? 7'b1111111 : hex7(nib);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            disp_q <= 16'h0000;
            an_q   <= 4'b1111;
            seg_q  <= 7'b1111111;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised scoreboard bench: three driver configurations share one stimulus
// stream; a cycle-count reference model predicts every registered output.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value = 16'h0;
    logic        load_en = 1'b0;
    logic        blank = 1'b0;

    logic [3:0] an_w  [3];
    logic [6:0] seg_w [3];
    logic       dp_w  [3];

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) u_d0 (
        .clk(clk), .reset(reset), .value(value), .load_en(load_en), .blank(blank),
        .an(an_w[0]), .seg(seg_w[0]), .dp(dp_w[0]));
    seg7_scan_driver #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) u_d1 (
        .clk(clk), .reset(reset), .value(value), .load_en(load_en), .blank(blank),
        .an(an_w[1]), .seg(seg_w[1]), .dp(dp_w[1]));
    seg7_scan_driver #(.REFRESH_DIV(1), .LZ_BLANK(1'b1)) u_d2 (
        .clk(clk), .reset(reset), .value(value), .load_en(load_en), .blank(blank),
        .an(an_w[2]), .seg(seg_w[2]), .dp(dp_w[2]));

    int unsigned DIV [3] = '{4, 4, 1};
    bit          LZ  [3] = '{1'b1, 1'b0, 1'b1};
    logic [6:0]  HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Model state: cycles since reset release and the captured value.
    int unsigned m_n    [3];
    logic [15:0] m_disp [3];
    logic [11:0] exp_q  [3][$];

    int checks = 0;
    int errors = 0;

    task automatic cyc(input logic r, input logic [15:0] v, input logic le, input logic bl);
        reset = r; value = v; load_en = le; blank = bl;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            logic [11:0] e;
            int unsigned k;
            int unsigned nb;
            bit          off;
            if (!r) begin
                e = {4'b1111, 7'b1111111, 1'b1};
                m_n[d] = 0;
                m_disp[d] = 16'h0;
            end else begin
                k   = (m_n[d] / DIV[d]) % 4;
                nb  = (32'(m_disp[d]) >> (4 * k)) & 32'hF;
                off = bl || (LZ[d] && k > 0 && (32'(m_disp[d]) >> (4 * k)) == 0);
                if (off) e = {4'b1111, 7'b1111111, 1'b1};
                else     e = {~(4'b0001 << k), HEX[nb], 1'b1};
                if ((m_n[d] % DIV[d]) == DIV[d] - 1 && k == 3 && le) m_disp[d] = v;
                m_n[d]++;
            end
            exp_q[d].push_back(e);
        end
        #1;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (exp_q[d].size() > 0) begin
                logic [11:0] e;
                e = exp_q[d].pop_front();
                checks++;
                if ({an_w[d], seg_w[d], dp_w[d]} !== e) begin
                    errors++;
                    $display("FAIL dut%0d outputs @%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                             d, $time, an_w[d], seg_w[d], dp_w[d], e[11:8], e[7:1], e[0]);
                end
            end
        end
    end

    initial begin
        // Reset, then 1234 captured and displayed
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (40) cyc(1'b1, 16'h1234, 1'b1, 1'b0);
        // Leading-zero suppression case
        repeat (32) cyc(1'b1, 16'h00A0, 1'b1, 1'b0);
        // Tearing: FFFF captured, then changed mid-frame
        repeat (20) cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
        repeat (40) cyc(1'b1, 16'h0000, 1'b1, 1'b0);
        repeat (8)  cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
        // Hold across three frames while value wanders
        repeat (48) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
        // Blank pulse mid-frame
        repeat (5)  cyc(1'b1, 16'hC0DE, 1'b1, 1'b1);
        repeat (24) cyc(1'b1, 16'hC0DE, 1'b1, 1'b0);
        // Reset mid-frame loses the pending capture
        repeat (6)  cyc(1'b1, 16'h5A5A, 1'b1, 1'b0);
        cyc(1'b0, 16'h5A5A, 1'b1, 1'b0);
        repeat (10) cyc(1'b1, 16'h5A5A, 1'b0, 1'b0);
        // Random traffic: mixed value widths to exercise leading zeros
        for (int i = 0; i < 600; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            case ($urandom_range(3))
                0: v = v & 16'h000F;
                1: v = v & 16'h00FF;
                2: v = v & 16'h0FFF;
                default: ;
            endcase
            cyc(($urandom_range(99) != 0), v, ($urandom_range(3) != 0),
                ($urandom_range(19) == 0));
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin
                errors++;
                $display("FAIL dut%0d drain: %0d pending, want 0", d, exp_q[d].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
